and8_operand_loader: RTL and testbench

Bit-serial front end for the 8-bit bitwise AND stage. It shifts in two 8-bit operands, LSB first, over a single serial line with a valid/ready handshake. It presents the operands as stable parallel words on `in1`/`in2` with a valid/ready handshake towards the AND stage. The operand words are updated atomically, so the downstream gate never sees a partially loaded operand.

---
 rtl/and8_operand_loader.sv | 122 ++++++++++++
 tb/tb_and8_operand_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/and8_operand_loader.sv
// Bit-serial operand loader for the 8-bit AND stage: shifts in A then B (LSB first)
// and presents both as a registered, atomically updated pair with valid/ready.
module and8_operand_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic             op_valid,
  input  logic             op_ready
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    PRESENT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic             op_valid_q, op_valid_d;
  logic             accept;
  logic [WIDTH-1:0] sh_a_next;
  logic [WIDTH-1:0] sh_b_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_valid_d = op_valid_q;
    ser_ready  = (state_q != PRESENT);
    accept     = ser_valid && ser_ready;
    sh_a_next  = {ser_in, sh_a_q[WIDTH-1:1]};
    sh_b_next  = {ser_in, sh_b_q[WIDTH-1:1]};

    if (clr) begin
      state_d    = LOAD_A;
      cnt_d      = '0;
      op_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (accept) begin
            sh_a_d = sh_a_next;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            sh_b_d = sh_b_next;
            if (cnt_q == CNT_LAST) begin
              // B's last bit goes straight into in2 so the pair lands on one edge
              cnt_d      = '0;
              in1_d      = sh_a_q;
              in2_d      = sh_b_next;
              op_valid_d = 1'b1;
              state_d    = PRESENT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (op_valid_q && op_ready) begin
            op_valid_d = 1'b0;
            state_d    = LOAD_A;
          end
        end
        default: begin
          state_d    = LOAD_A;
          cnt_d      = '0;
          op_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign in1      = in1_q;
  assign in2      = in2_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_and8_operand_loader.sv
// Bench for and8_operand_loader: directed scenarios plus random traffic, all
// checked every cycle against a bit-position model of the serial protocol.
module tb_and8_operand_loader;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         ser_in;
  logic         ser_valid;
  logic         ser_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         op_valid;
  logic         op_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  and8_operand_loader #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ser_in   (ser_in),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .in1      (in1),
    .in2      (in2),
    .op_valid (op_valid),
    .op_ready (op_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model: the k-th accepted bit of a pair lands directly at its bit position.
  int           m_k;
  logic         m_valid;
  logic [W-1:0] m_a, m_b, m_in1, m_in2;

  function automatic logic [W-1:0] setbit(input logic [W-1:0] v, input int i, input logic b);
    logic [W-1:0] r;
    r    = v;
    r[i] = b;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_valid <= 1'b0;
      m_a <= '0; m_b <= '0; m_in1 <= '0; m_in2 <= '0;
    end else if (clr) begin
      m_k <= 0; m_valid <= 1'b0;
    end else if (m_valid) begin
      if (op_ready) m_valid <= 1'b0;
    end else if (ser_valid) begin
      if (m_k < W) m_a <= setbit(m_a, m_k, ser_in);
      else         m_b <= setbit(m_b, m_k - W, ser_in);
      if (m_k == 2*W - 1) begin
        m_in1   <= m_a;
        m_in2   <= setbit(m_b, W - 1, ser_in);
        m_valid <= 1'b1;
        m_k     <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ser_ready", 32'(ser_ready), 32'(!m_valid));
      chk("cyc_op_valid", 32'(op_valid), 32'(m_valid));
      chk("cyc_in1", 32'(in1), 32'(m_in1));
      chk("cyc_in2", 32'(in2), 32'(m_in2));
    end
  end

  task automatic step(input logic sv, input logic si, input logic ordy, input logic c);
    ser_valid = sv;
    ser_in    = si;
    op_ready  = ordy;
    clr       = c;
    @(negedge clk);
  endtask

  // Sends nbits of {b,a} LSB first; gap inserts an idle cycle between bits.
  task automatic load_bits(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits,
                           input bit gap, input logic ordy);
    logic [2*W-1:0] word;
    word = {b, a};
    for (int i = 0; i < nbits; i++) begin
      step(1'b1, word[i], ordy, 1'b0);
      if (gap && i < nbits - 1) step(1'b0, 1'($urandom), ordy, 1'b0);
    end
  endtask

  task automatic expect_pair(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    chk({name, "_valid"}, 32'(op_valid), 32'd1);
    chk({name, "_in1"}, 32'(in1), 32'(a));
    chk({name, "_in2"}, 32'(in2), 32'(b));
  endtask

  initial begin
    int t0;
    int tprev;
    logic [W-1:0] ra, rb;

    rst = 1'b0; clr = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; op_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_op_valid", 32'(op_valid), 32'd0);
    chk("reset_ser_ready", 32'(ser_ready), 32'd1);
    chk("reset_in1", 32'(in1), 32'd0);
    chk("reset_in2", 32'(in2), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Continuous load
    t0 = cyc;
    load_bits(8'hA5, 8'h3C, 2*W, 1'b0, 1'b1);
    expect_pair("cont", 8'hA5, 8'h3C);
    chk("cont_and", 32'(in1 & in2), 32'h24);
    chk("cont_latency", 32'(cyc - t0), 32'd16);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cont_one_cycle", 32'(op_valid), 32'd0);
    chk("cont_ready_back", 32'(ser_ready), 32'd1);

    // Gapped input
    t0 = cyc;
    load_bits(8'hFF, 8'h81, 2*W, 1'b1, 1'b1);
    expect_pair("gap", 8'hFF, 8'h81);
    chk("gap_latency", 32'(cyc - t0), 32'd31);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure
    load_bits(8'h6B, 8'hD2, 2*W, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom), 1'b0, 1'b0);
      expect_pair("bp_hold", 8'h6B, 8'hD2);
      chk("bp_ser_ready", 32'(ser_ready), 32'd0);
    end
    step(1'b1, 1'($urandom), 1'b1, 1'b0);
    chk("bp_consumed", 32'(op_valid), 32'd0);

    // clr mid-load
    load_bits(8'h0F, 8'h05, W + 3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    load_bits(8'h12, 8'h34, 2*W, 1'b0, 1'b0);
    expect_pair("clr_load", 8'h12, 8'h34);

    // clr in PRESENT together with op_ready
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_present_valid", 32'(op_valid), 32'd0);
    chk("clr_present_in1", 32'(in1), 32'h12);
    load_bits(8'h9C, 8'h47, 2*W, 1'b0, 1'b0);
    expect_pair("after_clr", 8'h9C, 8'h47);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-load
    load_bits(8'hEE, 8'h77, 11, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_in1", 32'(in1), 32'd0);
    chk("rst_in2", 32'(in2), 32'd0);
    chk("rst_ser_ready", 32'(ser_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    load_bits(8'h5A, 8'hC3, 2*W, 1'b0, 1'b1);
    expect_pair("post_rst", 8'h5A, 8'hC3);

    // Back-to-back pairs
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tprev = cyc;
    for (int p = 0; p < 3; p++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      load_bits(ra, rb, 2*W, 1'b0, 1'b1);
      expect_pair("b2b", ra, rb);
      if (p > 0) chk("b2b_interval", 32'(cyc - tprev), 32'd17);
      tprev = cyc;
      step(1'b1, 1'($urandom), 1'b1, 1'b0);
    end

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
